// File: rtl/gpio_in_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_in_pkg : register addresses and defaults for gpio_in_avalon    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package gpio_in_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_POL  = 2'd3;

    // 20 ms at 50 MHz
    localparam int c_default_debounce_cycles = 1_000_000;

endpackage
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_debounce : 2-flop synchroniser plus optional stability counter  |
// | Counter is built only when GPIO_IN_DEBOUNCE_EN is defined.           |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module gpio_debounce
    import gpio_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic filt_o
);

    logic [1:0] r_sync_q;
    logic       r_filt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_q <= 2'b00;
        end else begin
            r_sync_q <= {r_sync_q[0], pin_i};
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt_q;
    logic [c_cnt_w-1:0] w_cnt_d;
    logic               w_filt_d;

    // Any cycle where the synchronised level agrees with filt restarts the count.
    always_comb begin
        w_cnt_d  = '0;
        w_filt_d = r_filt_q;
        if (r_sync_q[1] != r_filt_q) begin
            if (r_cnt_q >= c_cnt_max) begin
                w_filt_d = ~r_filt_q;
            end else begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_q  <= '0;
            r_filt_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_filt_q <= w_filt_d;
        end
    end
`else
    logic [31:0] w_unused_cycles;
    assign w_unused_cycles = 32'(DEBOUNCE_CYCLES);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_q <= 1'b0;
        end else begin
            r_filt_q <= r_sync_q[1];
        end
    end
`endif

    assign filt_o = r_filt_q;

endmodule
`default_nettype wire

// File: rtl/gpio_in_avalon.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_in_avalon : Avalon-MM switch input port with sticky edge IRQ    |
// | Debounce filter enabled by defining GPIO_IN_DEBOUNCE_EN.             |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module gpio_in_avalon
    import gpio_in_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] gpio_in
);

    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] r_filt_q;
    logic [WIDTH-1:0] r_mask_q;
    logic [WIDTH-1:0] w_mask_d;
    logic [WIDTH-1:0] r_pol_q;
    logic [WIDTH-1:0] w_pol_d;
    logic [WIDTH-1:0] r_edge_q;
    logic [WIDTH-1:0] w_edge_d;
    logic [WIDTH-1:0] w_edge_det;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      r_rdata_q;
    logic [31:0]      w_rdata_d;
    logic             r_irq_q;
    logic             w_unused_wdata;

    assign w_unused_wdata = ^writedata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            gpio_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .pin_i  (gpio_in[i]),
                .filt_o (w_filt[i])
            );
        end
    endgenerate

    always_comb begin
        w_mask_d = r_mask_q;
        w_pol_d  = r_pol_q;
        w_clr    = '0;
        if (write) begin
            case (address)
                ADDR_MASK: w_mask_d = writedata[WIDTH-1:0];
                ADDR_POL:  w_pol_d  = writedata[WIDTH-1:0];
                ADDR_EDGE: w_clr    = writedata[WIDTH-1:0];
                default:   ;
            endcase
        end

        // A fresh edge is ORed in after the clear so it is never lost.
        w_edge_det = (w_filt & ~r_filt_q & ~r_pol_q) | (~w_filt & r_filt_q & r_pol_q);
        w_edge_d   = (r_edge_q & ~w_clr) | w_edge_det;

        // Register values here are pre-write, so a combined read/write sees old data.
        w_rdata_d = r_rdata_q;
        if (read) begin
            w_rdata_d = '0;
            case (address)
                ADDR_DATA: w_rdata_d[WIDTH-1:0] = w_filt;
                ADDR_MASK: w_rdata_d[WIDTH-1:0] = r_mask_q;
                ADDR_EDGE: w_rdata_d[WIDTH-1:0] = r_edge_q;
                ADDR_POL:  w_rdata_d[WIDTH-1:0] = r_pol_q;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_q  <= '0;
            r_mask_q  <= '0;
            r_pol_q   <= '0;
            r_edge_q  <= '0;
            r_rdata_q <= '0;
            r_irq_q   <= 1'b0;
        end else begin
            r_filt_q  <= w_filt;
            r_mask_q  <= w_mask_d;
            r_pol_q   <= w_pol_d;
            r_edge_q  <= w_edge_d;
            r_rdata_q <= w_rdata_d;
            r_irq_q   <= |(r_edge_q & r_mask_q);
        end
    end

    assign readdata = r_rdata_q;
    assign irq      = r_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_avalon.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gpio_in_avalon : self-checking bench for gpio_in_avalon           |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_gpio_in_avalon;

    localparam int c_width = 10;
    localparam int c_db    = 8;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int c_lat   = 2 + c_db;
    localparam int c_mid   = 6;
`else
    localparam int c_lat   = 3;
    localparam int c_mid   = 1;
`endif

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_EDGE = 2'd2;
    localparam logic [1:0] A_POL  = 2'd3;

    logic               clk;
    logic               reset;
    logic [1:0]         address;
    logic               read;
    logic               write;
    logic [31:0]        writedata;
    logic [31:0]        readdata;
    logic               irq;
    logic [c_width-1:0] gpio_in;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] data;
        string       name;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[11];

    gpio_in_avalon #(
        .WIDTH           (c_width),
        .DEBOUNCE_CYCLES (c_db)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .gpio_in   (gpio_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        read    = 1'b1;
        sb_q.push_back('{exp, name});
        tick(1);
        read    = 1'b0;
    endtask

    task automatic check_irq(input string name, input logic exp);
        check(name, {31'b0, irq}, {31'b0, exp});
    endtask

    // Read data is checked on the falling edge after the sampling edge.
    always @(posedge clk) begin
        if (read) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_underflow: got read data 0x%0h with no expectation", readdata);
            end else begin
                sb_e = sb_q.pop_front();
                check(sb_e.name, readdata, sb_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{A_DATA, 1'b0, 32'h0,        32'h0,   "rst_data"};
        vecs[1]  = '{A_MASK, 1'b0, 32'h0,        32'h0,   "rst_mask"};
        vecs[2]  = '{A_EDGE, 1'b0, 32'h0,        32'h0,   "rst_edge"};
        vecs[3]  = '{A_POL,  1'b0, 32'h0,        32'h0,   "rst_pol"};
        vecs[4]  = '{A_MASK, 1'b1, 32'h155,      32'h155, "mask_rw"};
        vecs[5]  = '{A_MASK, 1'b1, 32'hFFFF_FFFF, 32'h3FF, "mask_upper_bits"};
        vecs[6]  = '{A_POL,  1'b1, 32'h2AA,      32'h2AA, "pol_rw"};
        vecs[7]  = '{A_DATA, 1'b1, 32'h3FF,      32'h0,   "data_write_ignored"};
        vecs[8]  = '{A_EDGE, 1'b1, 32'h3FF,      32'h0,   "edge_w1c_empty"};
        vecs[9]  = '{A_MASK, 1'b1, 32'h0,        32'h0,   "mask_restore"};
        vecs[10] = '{A_POL,  1'b1, 32'h0,        32'h0,   "pol_restore"};

        reset     = 1'b1;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'h0;
        gpio_in   = '0;
        tick(3);
        reset = 1'b0;
        check("rst_readdata", readdata, 32'h0);
        check_irq("rst_irq", 1'b0);

        // Register access table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
            check_irq({vecs[i].name, "_irq"}, 1'b0);
        end

        // All switches high: debounced value and rising edges on every bit
        gpio_in = 10'h3FF;
        tick(12);
        bus_read(A_DATA, 32'h3FF, "all_high_data");
        bus_read(A_EDGE, 32'h3FF, "all_high_edge");
        bus_write(A_EDGE, 32'h3FF);
        bus_read(A_EDGE, 32'h0, "edge_cleared");

`ifdef GPIO_IN_DEBOUNCE_EN
        // Chatter on bit 0 shorter than the debounce window
        for (int i = 0; i < 14; i++) begin
            gpio_in[0] = ~gpio_in[0];
            bus_read(A_DATA, 32'h3FF, "chatter_data");
            bus_read(A_EDGE, 32'h0, "chatter_edge");
            tick(1);
        end
        tick(c_lat + 2);
        bus_read(A_DATA, 32'h3FF, "post_chatter_data");
        bus_read(A_EDGE, 32'h0, "post_chatter_edge");
`endif

        // Falling edge on bit 2 with interrupt enabled
        bus_write(A_MASK, 32'h004);
        bus_write(A_POL, 32'h004);
        gpio_in = 10'h3FB;
        tick(c_lat + 1);
        check_irq("irq_before_latency", 1'b0);
        tick(1);
        check_irq("irq_at_latency", 1'b1);
        bus_read(A_EDGE, 32'h004, "fall_edge_cap");
        bus_write(A_EDGE, 32'h004);
        check_irq("irq_one_after_w1c", 1'b1);
        tick(1);
        check_irq("irq_two_after_w1c", 1'b0);

        // W1C coinciding with a new falling edge: the set wins
        bus_write(A_POL, 32'h000);
        gpio_in = 10'h3FF;
        tick(c_lat + 2);
        check_irq("irq_rise_bit2", 1'b1);
        bus_write(A_POL, 32'h004);
        gpio_in = 10'h3FB;
        tick(c_lat);
        bus_write(A_EDGE, 32'h004);
        check_irq("irq_w1c_collide", 1'b1);
        tick(2);
        check_irq("irq_w1c_collide_hold", 1'b1);
        bus_read(A_EDGE, 32'h004, "edge_w1c_collide");

        // Simultaneous read and write returns the old value
        address   = A_MASK;
        writedata = 32'h0F0;
        read      = 1'b1;
        write     = 1'b1;
        sb_q.push_back('{32'h004, "rw_same_cycle"});
        tick(1);
        read  = 1'b0;
        write = 1'b0;
        bus_read(A_MASK, 32'h0F0, "rw_new_value");

        // Reset during a read, then reset in the middle of a debounce count
        reset   = 1'b1;
        address = A_EDGE;
        read    = 1'b1;
        sb_q.push_back('{32'h0, "rst_during_read"});
        tick(1);
        read    = 1'b0;
        gpio_in = '0;
        tick(2);
        reset = 1'b0;
        check_irq("rst2_irq", 1'b0);
        bus_read(A_MASK, 32'h0, "rst2_mask");
        bus_read(A_EDGE, 32'h0, "rst2_edge");
        gpio_in = 10'h020;
        tick(c_mid);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        bus_read(A_DATA, 32'h0, "mid_rst_data");
        tick(c_lat - 2);
        bus_read(A_DATA, 32'h0, "mid_rst_not_yet");
        bus_read(A_DATA, 32'h020, "mid_rst_fresh");
        bus_read(A_EDGE, 32'h020, "mid_rst_edge");
        check_irq("mid_rst_irq_masked", 1'b0);

        tick(2);
        check("sb_drain", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
